// File: rtl/regfile_pkg.sv
// Shared types and sizes for the integer register-file write path.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INIT,
        GNT_WB,
        GNT_AUX
    } gnt_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Zero-init sweep sequencer: walks addresses 1..NumRegs-1, one per enabled cycle.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NumRegs = NUM_REGS,
    localparam int unsigned AddrW = $clog2(NumRegs)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [AddrW-1:0] addr_o,
    output logic             done_o
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumRegs - 1);

    logic [AddrW-1:0] cnt_q, cnt_d;

    assign addr_o = cnt_q;
    // Asserted while the last address is being issued.
    assign done_o = en_i && (cnt_q == LastAddr);

    // Advance the sweep address; x0 is skipped by starting at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !done_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sweep counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= AddrW'(1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port owner: zero-init sweep, then wb/aux arbitration with starvation stall.
module regfile_wr_ctrl #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned AddrW = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [AddrW-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    input  logic [AddrW-1:0]  aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_ready,
    output logic              rf_write,
    output logic [AddrW-1:0]  rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic              init_busy,
    output logic              stall_req
);
    import regfile_pkg::*;

    localparam int unsigned      CntW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]  StarveMax = CntW'(STARVE_LIMIT);

    state_e            state_q, state_d;
    gnt_e              gnt;
    logic              init_done;
    logic [AddrW-1:0]  init_addr;
    logic              rf_write_q, rf_write_d;
    logic [AddrW-1:0]  rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic              stall_q, stall_d;

    regfile_init_seq #(
        .NumRegs (NUM_REGS)
    ) u_init_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == ST_INIT),
        .addr_o (init_addr),
        .done_o (init_done)
    );

    // Fixed-priority grant: sweep owns the port in INIT, then wb beats aux.
    always_comb begin
        gnt = GNT_NONE;
        if (state_q == ST_INIT) begin
            gnt = GNT_INIT;
        end else if (wb_valid) begin
            gnt = GNT_WB;
        end else if (aux_valid) begin
            gnt = GNT_AUX;
        end
    end

    assign aux_ready = (gnt == GNT_AUX);

    // Next-state for the write port, FSM, and starvation tracking.
    always_comb begin
        state_d    = state_q;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        starve_d   = starve_q;
        unique case (gnt)
            GNT_INIT: begin
                rf_write_d = 1'b1;
                rf_addr_d  = init_addr;
                rf_data_d  = '0;
                if (init_done) begin
                    state_d = ST_RUN;
                end
            end
            GNT_WB: begin
                // x0 is hardwired zero: consume the request but suppress the write.
                rf_write_d = (wb_addr != '0);
                rf_addr_d  = wb_addr;
                rf_data_d  = wb_data;
            end
            GNT_AUX: begin
                rf_write_d = (aux_addr != '0);
                rf_addr_d  = aux_addr;
                rf_data_d  = aux_data;
            end
            default: ;
        endcase
        if (state_q == ST_RUN) begin
            if (aux_ready) begin
                starve_d = '0;
            end else if (aux_valid && (starve_q != StarveMax)) begin
                starve_d = starve_q + 1'b1;
            end
        end
        // Drops right after the handshake because the counter clears in the same cycle.
        stall_d = !aux_ready && (starve_q == StarveMax);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
        end
    end

    assign rf_write  = rf_write_q;
    assign rf_wrAddr = rf_addr_q;
    assign rf_wrData = rf_data_q;
    assign stall_req = stall_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: sweep, arbitration, starvation stall, x0, mid-sweep reset.
module tb_regfile_wr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_write;
    logic [4:0]  rf_wrAddr;
    logic [31:0] rf_wrData;
    logic        init_busy;
    logic        stall_req;

    int vectors;
    int miscompares;

    regfile_wr_ctrl #(
        .NUM_REGS     (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .aux_ready (aux_ready),
        .rf_write  (rf_write),
        .rf_wrAddr (rf_wrAddr),
        .rf_wrData (rf_wrData),
        .init_busy (init_busy),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Land 2ns after the active edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " rf_write"}, rf_write, 0);
        chk({tag, " rf_wrAddr"}, rf_wrAddr, 0);
        chk({tag, " rf_wrData"}, rf_wrData, 0);
        chk({tag, " stall_req"}, stall_req, 0);
        chk({tag, " init_busy"}, init_busy, 1);
        chk({tag, " aux_ready"}, aux_ready, 0);
    endtask

    // Runs the 31-cycle sweep after rst_n release, with both requesters asserted to prove they are ignored.
    task automatic check_sweep(input string tag);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk({tag, " rf_write"}, rf_write, 1);
            chk({tag, " rf_wrAddr"}, rf_wrAddr, k);
            chk({tag, " rf_wrData"}, rf_wrData, 0);
            chk({tag, " init_busy"}, init_busy, (k < 31) ? 1 : 0);
            chk({tag, " aux_ready"}, aux_ready, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        aux_valid = 1'b0;
        aux_addr  = '0;
        aux_data  = '0;

        // Reset state
        #3;
        chk_zero_outputs("reset");
        tick();
        tick();
        wb_valid  = 1'b1; wb_addr  = 5'd9;  wb_data  = 32'hFFFF_FFFF;
        aux_valid = 1'b1; aux_addr = 5'd10; aux_data = 32'h7777_7777;
        #1;
        chk("reset aux_ready with requests", aux_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-init sweep x1..x31
        check_sweep("sweep");
        chk("sweep end stall_req", stall_req, 0);

        // Plain wb write
        aux_valid = 1'b0;
        wb_valid  = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        chk("wb rf_write", rf_write, 1);
        chk("wb rf_wrAddr", rf_wrAddr, 5);
        chk("wb rf_wrData", rf_wrData, 32'hDEAD_BEEF);
        wb_valid = 1'b0;
        tick();
        chk("idle rf_write", rf_write, 0);

        // wb and aux together: wb wins, aux holds
        wb_valid  = 1'b1; wb_addr  = 5'd3; wb_data  = 32'h1111_1111;
        aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'h0000_1234;
        #1;
        chk("both aux_ready", aux_ready, 0);
        tick();
        chk("both rf_wrAddr", rf_wrAddr, 3);
        chk("both rf_wrData", rf_wrData, 32'h1111_1111);
        chk("both aux_ready held", aux_ready, 0);
        wb_valid = 1'b0;
        #1;
        chk("aux alone aux_ready", aux_ready, 1);
        tick();
        chk("aux rf_write", rf_write, 1);
        chk("aux rf_wrAddr", rf_wrAddr, 7);
        chk("aux rf_wrData", rf_wrData, 32'h0000_1234);
        aux_valid = 1'b0;
        #1;
        chk("aux done aux_ready", aux_ready, 0);
        tick();
        chk("aux done rf_write", rf_write, 0);
        chk("aux done stall_req", stall_req, 0);

        // Starvation: stall_req rises 5 cycles after aux_valid under continuous wb
        wb_valid  = 1'b1; wb_addr  = 5'd4; wb_data  = 32'hA5A5_0004;
        aux_valid = 1'b1; aux_addr = 5'd8; aux_data = 32'h0000_CAFE;
        for (int n = 1; n <= 6; n++) begin
            tick();
            chk("starve stall_req", stall_req, (n >= 5) ? 1 : 0);
            chk("starve rf_wrAddr", rf_wrAddr, 4);
            chk("starve aux_ready", aux_ready, 0);
        end
        wb_valid = 1'b0;
        #1;
        chk("starve release aux_ready", aux_ready, 1);
        chk("starve release stall_req", stall_req, 1);
        tick();
        chk("starve aux rf_write", rf_write, 1);
        chk("starve aux rf_wrAddr", rf_wrAddr, 8);
        chk("starve aux rf_wrData", rf_wrData, 32'h0000_CAFE);
        chk("starve cleared stall_req", stall_req, 0);

        // aux write to x0: handshake completes, no rf write
        aux_addr = 5'd0; aux_data = 32'h0000_0055;
        #1;
        chk("aux x0 aux_ready", aux_ready, 1);
        tick();
        chk("aux x0 rf_write", rf_write, 0);
        aux_valid = 1'b0;
        wb_valid  = 1'b1; wb_addr = 5'd12; wb_data = 32'h0BAD_F00D;
        tick();
        chk("wb x12 rf_write", rf_write, 1);
        wb_addr = 5'd0;
        tick();
        chk("wb x0 rf_write", rf_write, 0);
        wb_valid = 1'b0;

        // Reset during run, then reset again mid-sweep at address 12
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("run reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("pre-abort rf_wrAddr", rf_wrAddr, k);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("sweep abort");
        wb_valid  = 1'b1; wb_addr  = 5'd9;  wb_data  = 32'hFFFF_FFFF;
        aux_valid = 1'b1; aux_addr = 5'd10; aux_data = 32'h7777_7777;
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep("resweep");
        wb_valid  = 1'b0;
        aux_valid = 1'b0;
        tick();
        chk("resweep done rf_write", rf_write, 0);
        chk("resweep done init_busy", init_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
